// File: rtl/toll_pkg.sv
// Shared fee constants, class encodings and record field widths
// for the toll record buffer.
package toll_pkg;

  localparam int SEQ_W   = 8;
  localparam int CLASS_W = 2;
  localparam int DROP_W  = 8;

  localparam int BASE_FEE_C1   = 20;
  localparam int BASE_FEE_C2   = 35;
  localparam int BASE_FEE_C3   = 50;
  localparam int VIOLATION_FEE = 200;
  localparam int PENALTY_FEE   = 100;

  typedef enum logic [CLASS_W-1:0] {
    CLS_NONE = 2'b00,
    CLS_1    = 2'b01,
    CLS_2    = 2'b10,
    CLS_3    = 2'b11
  } cls_e;

  function automatic logic [31:0] class_fee(
    input logic [CLASS_W-1:0] cls
  );
    logic [31:0] f;
    f = 32'(VIOLATION_FEE);
    unique case (cls)
      CLS_1:   f = 32'(BASE_FEE_C1);
      CLS_2:   f = 32'(BASE_FEE_C2);
      CLS_3:   f = 32'(BASE_FEE_C3);
      default: f = 32'(VIOLATION_FEE);
    endcase
    return f;
  endfunction

endpackage

// File: rtl/toll_fifo.sv
// Circular record store; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module toll_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              wdata,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero when nothing is stored.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; a pop frees the slot a same-cycle push needs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Record storage, no reset needed: pointers define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/toll_record_buffer.sv
// Turns ETC done pulses into fee records and buffers them.
// Optional macro TOLL_PENALTY_EN adds an overspeed penalty fee.
module toll_record_buffer
  import toll_pkg::*;
#(
  parameter int WIDTH_SPEED = 14,
  parameter int FEE_WIDTH   = 16,
  parameter int DEPTH       = 4,
  parameter int SPEED_LIMIT = 80
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done,
  input  logic [WIDTH_SPEED-1:0]   speed,
  input  logic [1:0]               valid_Epass,
  input  logic                     rec_ready,
  input  logic                     clr_ovf,
  output logic                     rec_valid,
  output logic [7:0]               rec_seq,
  output logic [1:0]               rec_class,
  output logic [WIDTH_SPEED-1:0]   rec_speed,
  output logic [FEE_WIDTH-1:0]     rec_fee,
  output logic                     rec_violation,
  output logic                     rec_overspeed,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt,
  output logic                     overflow
);

  localparam int RW = SEQ_W + CLASS_W + WIDTH_SPEED + FEE_WIDTH + 2;

  localparam logic [WIDTH_SPEED:0] LIMIT =
    (WIDTH_SPEED+1)'(SPEED_LIMIT);

  localparam logic [31:0] FEE_MAX =
    (FEE_WIDTH >= 32) ? 32'hFFFF_FFFF
                      : ((32'd1 << FEE_WIDTH) - 32'd1);

  logic                   done_q;
  logic                   armed;
  logic                   evt;
  logic                   s1_vld;
  logic [WIDTH_SPEED-1:0] s1_speed;
  logic [CLASS_W-1:0]     s1_cls;
  logic [SEQ_W-1:0]       s1_seq;
  logic [SEQ_W-1:0]       seq_cnt;

  logic                   s2_over;
  logic                   s2_viol;
  logic [31:0]            s2_sum;
  logic [FEE_WIDTH-1:0]   s2_fee;
  logic [RW-1:0]          wdata;
  logic [RW-1:0]          rdata;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   drop;

  // armed blocks a done level that was already high out of reset.
  assign evt = done & ~done_q & armed;

  // Edge detector state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      done_q <= done;
      armed  <= armed | ~done;
    end
  end

  // Stage 1: capture the measurement and number the event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_speed <= '0;
      s1_cls   <= '0;
      s1_seq   <= '0;
      seq_cnt  <= '0;
    end else begin
      s1_vld <= evt;
      if (evt) begin
        s1_speed <= speed;
        s1_cls   <= valid_Epass;
        s1_seq   <= seq_cnt;
        seq_cnt  <= seq_cnt + 1'b1;
      end
    end
  end

  // Stage 2: fee and flags, summed wide then saturated.
  always_comb begin
    s2_over = ({1'b0, s1_speed} > LIMIT);
    s2_viol = (s1_cls == CLS_NONE);
    s2_sum  = class_fee(s1_cls);
`ifdef TOLL_PENALTY_EN
    if (s2_over) s2_sum = s2_sum + 32'(PENALTY_FEE);
`endif
    if (s2_sum > FEE_MAX) s2_fee = '1;
    else                  s2_fee = FEE_WIDTH'(s2_sum);
  end

  assign wdata = {s1_seq, s1_cls, s1_speed,
                  s2_fee, s2_viol, s2_over};

  assign pop  = rec_valid & rec_ready;
  assign drop = s1_vld & full & ~pop;

  toll_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_vld),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign rec_valid = ~empty;
  assign {rec_seq, rec_class, rec_speed,
          rec_fee, rec_violation, rec_overspeed} = rdata;

  // Drop accounting; a same-cycle drop wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
